uart_tx_piso: RTL and testbench

- Transmit half of the UART: parallel-in, serial-out framer that is the counterpart of the receive-side serial-to-parallel register.
- Accepts one byte per valid/ready handshake and serialises it onto the TX line: start bit, 8 data bits LSB first, optional parity bit, stop bit(s).
- Contains its own bit-period counter; no external baud tick is required.
- Sits between the register/FIFO interface and the TX pad.

---
 rtl/uart_tx_piso.sv | 159 +++++++++++++++
 tb/tb_uart_tx_piso.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_piso.sv
// UART transmit framer: accepts one byte per valid/ready handshake and
// shifts it out as start bit, 8 data bits LSB first, optional parity bit
// and one or two stop bits. Bit timing comes from an internal divider, so
// no external baud tick is needed. Every output is driven from a flop.
//
// Handshake: a byte is taken on a rising edge where tx_valid and tx_ready
// are both high. tx_ready is high only in IDLE, and tx_data/tx_valid are
// ignored while it is low, so the source may change them freely mid-frame.
module uart_tx_piso #(
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       reg_clk,
  input  logic       reg_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_data_out,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Last divider value of a bit period and last stop-bit index.
  localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        ODD_BIT   = (PARITY_ODD != 0);
  localparam logic        HAS_PAR   = (PARITY_EN != 0);

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [8:0]  shift_q, shift_d;
  logic        line_q, line_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        bit_end;

  assign accept  = tx_valid && ready_q;
  assign bit_end = (div_q == DIV_LAST);

  // Next-state logic: divider, bit counter, shift register and frame state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          div_d   = 16'd0;
          bit_d   = 3'd0;
          // Parity is fixed at acceptance from the latched byte.
          shift_d = {(^tx_data) ^ ODD_BIT, tx_data};
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          // After the 8th shift the parity bit sits in shift_q[0].
          shift_d = {1'b0, shift_q[8:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = 3'd0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bit_d   = 3'd0;
      end
    endcase

    // The divider runs only inside a frame and wraps on every bit boundary.
    if (state_q != S_IDLE) begin
      div_d = bit_end ? 16'd0 : div_q + 16'd1;
    end
  end

  // Registered outputs are derived from the next-state values so they line
  // up with the state they describe in the same cycle.
  always_comb begin
    line_d  = 1'b1;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (div_d == DIV_LAST) && (bit_d == STOP_LAST);
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = shift_d[0];
      default:  line_d = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      state_q <= S_IDLE;
      div_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 9'd0;
      line_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign serial_data_out = line_q;
  assign tx_ready        = ready_q;
  assign tx_busy         = busy_q;
  assign tx_done         = done_q;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Bench for uart_tx_piso: three instances with different framing options
// share one clock and reset. A reference model builds the expected line
// waveform per clock directly from the frame layout.
module tb_uart_tx_piso;

  localparam int B = 4;
  // Instance configurations: 0 even parity, 1 odd parity, 2 no parity/2 stop.
  localparam int PE[3] = '{1, 1, 0};
  localparam int OD[3] = '{0, 1, 0};
  localparam int ST[3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] valid_v = 3'b000;
  logic [7:0] data_v [3];
  wire  [2:0] ready_w, line_w, busy_w, done_w;

  int tests = 0;
  int fails = 0;

  // Per-clock expectation {line, done, ready}.
  logic [2:0] exp_q[$];
  logic [7:0] stim_q[$];

  // Clock and reset block.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  uart_tx_piso #(.BAUD_DIV(B), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .reg_clk(clk), .reg_rst_n(rst_n), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_w[0]), .serial_data_out(line_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_piso #(.BAUD_DIV(B), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .reg_clk(clk), .reg_rst_n(rst_n), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_w[1]), .serial_data_out(line_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_piso #(.BAUD_DIV(B), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_nopar (
    .reg_clk(clk), .reg_rst_n(rst_n), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_w[2]), .serial_data_out(line_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  function automatic int frame_len(input int idx);
    return (1 + 8 + PE[idx] + ST[idx]) * B;
  endfunction

  // Reference model: frame of bit slots, each held B clocks, then one idle clock.
  function automatic void push_frame(input int idx, input logic [7:0] b);
    int   nb;
    int   slot;
    logic ln;
    nb = 1 + 8 + PE[idx] + ST[idx];
    for (int c = 0; c < nb * B; c++) begin
      slot = c / B;
      if (slot == 0) ln = 1'b0;
      else if (slot <= 8) ln = b[slot-1];
      else if (PE[idx] == 1 && slot == 9) ln = (^b) ^ OD[idx][0];
      else ln = 1'b1;
      exp_q.push_back({ln, (c == nb * B - 1), 1'b0});
    end
    exp_q.push_back(3'b101);
  endfunction

  // Sends every byte in stim_q on one instance, offering the next byte in the
  // idle clock after each frame, and checks the line every clock.
  task automatic play_frames(input int idx, input bit rand_valid, input string name);
    int n;
    int len;
    int pos;
    int j;
    logic [3:0] got;
    logic [3:0] want;
    exp_q.delete();
    foreach (stim_q[i]) push_frame(idx, stim_q[i]);
    repeat (3) exp_q.push_back(3'b101);
    n   = stim_q.size();
    len = frame_len(idx);
    @(negedge clk);
    valid_v[idx] = 1'b1;
    data_v[idx]  = stim_q[0];
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk);
      got  = {line_w[idx], done_w[idx], ready_w[idx], busy_w[idx]};
      want = {exp_q[k-1], ~exp_q[k-1][0]};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL %s cycle %0d {line,done,ready,busy} got %b expected %b", name, k, got, want);
      end
      pos = k % (len + 1);
      j   = k / (len + 1);
      if (pos == 0) begin
        if (j < n) begin
          valid_v[idx] = 1'b1;
          data_v[idx]  = stim_q[j];
        end else begin
          valid_v[idx] = 1'b0;
        end
      end else if (k > n * (len + 1)) begin
        valid_v[idx] = 1'b0;
      end else begin
        // Inputs are don't-care mid-frame: scramble them.
        data_v[idx] = 8'($urandom);
        valid_v[idx] = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    valid_v[idx] = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      got = {line_w[i], ready_w[i], busy_w[i], done_w[i]};
      tests++;
      if (got !== 4'b1100) begin
        fails++;
        $display("FAIL reset dut%0d {line,ready,busy,done} got %b expected 1100", i, got);
      end
    end
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_even_a5();
    stim_q = '{8'hA5};
    play_frames(0, 1'b0, "even_a5");
  endtask

  task automatic test_odd_07();
    stim_q = '{8'h07};
    play_frames(1, 1'b0, "odd_07");
  endtask

  task automatic test_two_stop_00();
    stim_q = '{8'h00};
    play_frames(2, 1'b0, "two_stop_00");
  endtask

  task automatic test_back_to_back();
    stim_q = '{8'h31, 8'h32};
    play_frames(0, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got;
    @(negedge clk);
    valid_v[0] = 1'b1;
    data_v[0]  = 8'hFF;
    @(negedge clk);
    valid_v[0] = 1'b0;
    // Cycles 17..20 carry data bit 3; stop in cycle 18.
    repeat (17) @(negedge clk);
    got = {line_w[0], busy_w[0]};
    tests++;
    if (got !== 2'b11) begin
      fails++;
      $display("FAIL rst_mid pre {line,busy} got %b expected 11", got);
    end
    #1 rst_n = 1'b0;
    #1;
    got = {line_w[0], done_w[0], ready_w[0], busy_w[0]};
    tests++;
    if (got !== 4'b1010) begin
      fails++;
      $display("FAIL rst_mid during {line,done,ready,busy} got %b expected 1010", got);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      got = {line_w[0], done_w[0], ready_w[0], busy_w[0]};
      tests++;
      if (got !== 4'b1010) begin
        fails++;
        $display("FAIL rst_mid after cycle %0d {line,done,ready,busy} got %b expected 1010", k, got);
      end
    end
  endtask

  task automatic test_random();
    for (int idx = 0; idx < 3; idx++) begin
      for (int r = 0; r < 2; r++) begin
        stim_q.delete();
        repeat ($urandom_range(1, 3)) stim_q.push_back(8'($urandom));
        play_frames(idx, 1'b1, $sformatf("random_dut%0d_%0d", idx, r));
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
    test_reset();
    test_even_a5();
    test_odd_07();
    test_two_stop_00();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
